// File: rtl/frec_div_multi.sv
// frec_div_multi: multi-channel 50% duty clock divider with runtime half-period reload.
// Each channel toggles clk_div every cur_div cycles; new divisors take effect at a toggle or sync.
module frec_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 1000,
    parameter int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick
);
    logic [CHANNELS-1:0] pend_vld;
    logic                in_range;
    logic                accept;
    logic                good;

    always_comb begin
        in_range  = 32'(cfg_ch) < CHANNELS;
        cfg_ready = in_range ? !pend_vld[cfg_ch] : 1'b1;
        accept    = cfg_valid && cfg_ready;
        good      = in_range && (cfg_div != '0);
    end

    always_ff @(posedge clk_in) cfg_err <= reset ? 1'b0 : accept && !good;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] cur_div;
        logic [WIDTH-1:0] pend_div;
        logic             pv;
        logic             cd;
        logic             tk;
        logic             wr;
        logic             hit;
        assign wr          = accept && good && (32'(cfg_ch) == c);
        assign hit         = en[c] && (count == cur_div);
        assign pend_vld[c] = pv;
        assign clk_div[c]  = cd;
        assign tick[c]     = tk;
        // A write can only be accepted while nothing is pending, so it never races the apply below.
        always_ff @(posedge clk_in) begin
            if (reset) begin
                count    <= WIDTH'(1);
                cur_div  <= WIDTH'(DEFAULT_DIV);
                pend_div <= '0;
                pv       <= 1'b0;
                cd       <= 1'b0;
                tk       <= 1'b0;
            end else begin
                tk <= !sync && hit;
                cd <= sync ? 1'b0 : cd ^ hit;
                if (sync || hit) begin
                    count <= WIDTH'(1);
                    if (pv) begin
                        cur_div <= pend_div;
                        pv      <= 1'b0;
                    end
                end else if (en[c]) begin
                    count <= count + WIDTH'(1);
                end
                if (wr) begin
                    pend_div <= cfg_div;
                    pv       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frec_div_multi.sv
// tb_frec_div_multi: scoreboard bench; expected tick/cfg_err events are queued by the
// stimulus and consumed by a negedge monitor whenever the DUT pulses an output.
module tb_frec_div_multi;
    localparam int CH = 3;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] en = '0;
    logic          sync = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [31:0]   cfg_div = '0;
    logic          cfg_err;
    logic [CH-1:0] clk_div;
    logic [CH-1:0] tick;

    frec_div_multi #(.CHANNELS(CH), .WIDTH(32), .DEFAULT_DIV(1000)) dut (
        .clk_in(clk_in), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .clk_div(clk_div), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tq[CH][$];
    bit lq[CH][$];
    int eq[$];
    int n_tests = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    int et;
    bit el;
    int E0, S, S1, S2, R;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle;
        @(negedge clk_in);
        #1;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step;
    endtask

    task automatic push(input int ch, input int t, input bit l);
        tq[ch].push_back(t);
        lq[ch].push_back(l);
    endtask

    task automatic push_all(input int t, input bit l);
        for (int i = 0; i < CH; i++) push(i, t, l);
    endtask

    // Drive one write so that it is sampled (accepted) at edge k.
    task automatic wr(input int ch, input int d, input int k);
        run_to(k - 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = d;
        #1;
        chk("cfg_ready_before_write", cfg_ready, 1);
        step;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sync = 1'b0;
        cfg_valid = 1'b0;
        step;
        reset = 1'b0;
        en = '1;
        E0 = cyc;
    endtask

    task automatic chk_empty;
        for (int i = 0; i < CH; i++) chk($sformatf("tick_missing_ch%0d", i), tq[i].size(), 0);
        chk("cfg_err_missing", eq.size(), 0);
    endtask

    always @(negedge clk_in) begin
        if (mon_on) begin
            for (int i = 0; i < CH; i++) begin
                if (tick[i] === 1'b1) begin
                    if (tq[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tick_unexpected ch%0d: got tick=1, required 0 (cycle %0d)", i, cyc);
                    end else begin
                        et = tq[i].pop_front();
                        el = lq[i].pop_front();
                        chk($sformatf("tick_time_ch%0d", i), cyc, et);
                        chk($sformatf("clk_div_level_ch%0d", i), clk_div[i], el);
                    end
                end
            end
            if (cfg_err === 1'b1) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cfg_err_unexpected: got 1, required 0 (cycle %0d)", cyc);
                end else begin
                    et = eq.pop_front();
                    chk("cfg_err_time", cyc, et);
                end
            end
        end
    end

    initial begin
        // Default divisor, invalid writes, and a runtime reload of ch1 to 3.
        do_reset;
        settle;
        mon_on = 1'b1;
        chk("reset_clk_div", clk_div, 0);
        chk("reset_tick", tick, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        for (int i = 0; i < CH; i += 2) begin
            push(i, E0 + 1000, 1);
            push(i, E0 + 2000, 0);
            push(i, E0 + 3000, 1);
        end
        push(1, E0 + 1000, 1);
        for (int k = 1; 1000 + 3 * k <= 3000; k++) push(1, E0 + 1000 + 3 * k, (k % 2) == 0);
        eq.push_back(E0 + 100);
        wr(0, 0, E0 + 100);
        eq.push_back(E0 + 200);
        wr(3, 7, E0 + 200);
        wr(1, 3, E0 + 500);
        chk("ready_low_after_accept", cfg_ready, 0);
        run_to(E0 + 999);
        chk("ready_low_until_toggle", cfg_ready, 0);
        run_to(E0 + 1000);
        chk("ready_high_after_apply", cfg_ready, 1);
        run_to(E0 + 3000);
        settle;
        chk_empty;

        // Enable freeze on ch2 with cur_div=5 (applied through sync).
        do_reset;
        wr(2, 5, E0 + 1);
        sync = 1'b1;
        step;
        sync = 1'b0;
        S = cyc;
        chk("sync_applies_pending", cfg_ready, 1);
        push(2, S + 15, 1);
        push(2, S + 20, 0);
        run_to(S + 2);
        en = 3'b011;
        run_to(S + 12);
        en = 3'b111;
        run_to(S + 22);
        settle;
        chk_empty;

        // Divisors 4/6, then sync coincident with toggles and with a new write.
        do_reset;
        wr(0, 4, E0 + 1);
        wr(1, 6, E0 + 2);
        sync = 1'b1;
        step;
        sync = 1'b0;
        S1 = cyc;
        S2 = S1 + 12;
        push(0, S1 + 4, 1);
        push(0, S1 + 8, 0);
        push(1, S1 + 6, 1);
        for (int k = 1; k <= 6; k++) push(0, S2 + 2 * k, (k % 2) == 1);
        push(1, S2 + 6, 1);
        push(1, S2 + 9, 0);
        push(1, S2 + 12, 1);
        wr(0, 2, S1 + 9);
        chk("ch0_pending_ready_low", cfg_ready, 0);
        run_to(S2 - 1);
        sync = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = 2'd1;
        cfg_div = 3;
        #1;
        chk("ready_with_sync_write", cfg_ready, 1);
        step;
        sync = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = 2'd0;
        settle;
        chk("sync_clears_clk_div", clk_div, 0);
        chk("ch0_pending_applied_by_sync", cfg_ready, 1);
        run_to(S2 + 12);
        settle;
        chk_empty;

        // Reset in the second half-period with a pending write and a live cfg_err.
        do_reset;
        push_all(E0 + 1000, 1);
        wr(0, 7, E0 + 1200);
        eq.push_back(E0 + 1499);
        wr(3, 9, E0 + 1499);
        reset = 1'b1;
        step;
        reset = 1'b0;
        R = cyc;
        cfg_ch = 2'd0;
        settle;
        chk("midreset_clk_div", clk_div, 0);
        chk("midreset_tick", tick, 0);
        chk("midreset_cfg_err", cfg_err, 0);
        chk("midreset_pending_dropped", cfg_ready, 1);
        push_all(R + 1000, 1);
        push_all(R + 2000, 0);
        run_to(R + 2000);
        settle;
        chk_empty;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
